// File: rtl/nrzi_encoder.sv
`default_nettype none
// ============================================================================
// Module      : nrzi_encoder
// Description : Serial NRZI line encoder for the USB transmit bit path.
//               Data 0 toggles the line level, data 1 holds it. With bit
//               stuffing enabled, a toggle is inserted after STUFF_LEN
//               consecutive accepted 1s; the source is stalled through
//               bit_ready for that one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module nrzi_encoder #(
    parameter logic IDLE_LEVEL = 1'b1,
    parameter bit   STUFF_EN   = 1'b1,
    parameter int   STUFF_LEN  = 6
) (
    input  logic clk,
    input  logic nRST,
    input  logic curr_bit,
    input  logic bit_valid,
    output logic bit_ready,
    input  logic clear,
    output logic encoded_bit,
    output logic encoded_valid,
    output logic stuff_active
);

    localparam int CNT_W = $clog2(STUFF_LEN + 1);

    // Saturation value of the run counter and the count one short of it.
    localparam logic [CNT_W-1:0] STUFF_MAX  = CNT_W'(STUFF_LEN);
    localparam logic [CNT_W-1:0] STUFF_LAST = CNT_W'(STUFF_LEN - 1);

    // ST_STUFF means a stuffed toggle goes out on the next edge.
    typedef enum logic [0:0] {
        ST_DATA  = 1'b0,
        ST_STUFF = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] ones_cnt;
    logic [CNT_W-1:0] ones_nxt;
    logic             enc_nxt;
    logic             valid_nxt;
    logic             stuff_act_nxt;

    // The source is only stalled while a stuffed bit is pending.
    generate
        if (STUFF_EN) begin : g_stuff
            assign bit_ready = (state != ST_STUFF);
        end else begin : g_no_stuff
            assign bit_ready = 1'b1;
        end
    endgenerate

    // Next-state and next-output logic: clear, then stuff, then data, then idle.
    always_comb begin
        state_nxt     = state;
        ones_nxt      = ones_cnt;
        enc_nxt       = encoded_bit;
        valid_nxt     = 1'b0;
        stuff_act_nxt = 1'b0;

        if (clear) begin
            // End of packet: back to idle line, any pending stuff dropped.
            state_nxt = ST_DATA;
            ones_nxt  = '0;
            enc_nxt   = IDLE_LEVEL;
        end else if (state == ST_STUFF) begin
            // Stuffed 0: toggle regardless of bit_valid; curr_bit is not consumed.
            state_nxt     = ST_DATA;
            ones_nxt      = '0;
            enc_nxt       = ~encoded_bit;
            valid_nxt     = 1'b1;
            stuff_act_nxt = 1'b1;
        end else if (bit_valid) begin
            valid_nxt = 1'b1;
            if (!curr_bit) begin
                enc_nxt  = ~encoded_bit;
                ones_nxt = '0;
            end else begin
                if (ones_cnt != STUFF_MAX) begin
                    ones_nxt = ones_cnt + CNT_W'(1);
                end
                if (STUFF_EN && (ones_cnt == STUFF_LAST)) begin
                    state_nxt = ST_STUFF;
                end
            end
        end
        // Idle: line holds, run count is retained across the gap.
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (nRST) begin
            state         <= ST_DATA;
            ones_cnt      <= '0;
            encoded_bit   <= IDLE_LEVEL;
            encoded_valid <= 1'b0;
            stuff_active  <= 1'b0;
        end else begin
            state         <= state_nxt;
            ones_cnt      <= ones_nxt;
            encoded_bit   <= enc_nxt;
            encoded_valid <= valid_nxt;
            stuff_active  <= stuff_act_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nrzi_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nrzi_encoder
// Description : Self-checking bench for nrzi_encoder. A bit-stream model
//               predicts the line every cycle; directed sequences pin the
//               model with hand-computed values; random traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nrzi_encoder;

    localparam int RUN_LEN = 6;

    logic clk = 1'b0;
    logic nRST;
    logic curr_bit;
    logic bit_valid;
    logic bit_ready;
    logic clear;
    logic encoded_bit;
    logic encoded_valid;
    logic stuff_active;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: current line level, length of the current run of 1s in
    // the transmitted stream, and whether a stuffed 0 is owed next.
    logic m_line;
    int   m_run;
    logic m_owed;
    logic m_valid;
    logic m_stuffed;
    logic checking = 1'b0;

    nrzi_encoder #(
        .IDLE_LEVEL (1'b1),
        .STUFF_EN   (1'b1),
        .STUFF_LEN  (RUN_LEN)
    ) dut (
        .clk           (clk),
        .nRST          (nRST),
        .curr_bit      (curr_bit),
        .bit_valid     (bit_valid),
        .bit_ready     (bit_ready),
        .clear         (clear),
        .encoded_bit   (encoded_bit),
        .encoded_valid (encoded_valid),
        .stuff_active  (stuff_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    // Model of one clock edge, stated as the transmitted bit stream: each
    // transmitted 0 (data or stuffed) flips the line; a stream of RUN_LEN 1s
    // owes one stuffed 0 before the next data bit may go out.
    task automatic model_edge(input logic r, input logic c, input logic v, input logic b);
        if (r || c) begin
            m_line = 1'b1; m_run = 0; m_owed = 1'b0;
            m_valid = 1'b0; m_stuffed = 1'b0;
        end else if (m_owed) begin
            m_line = ~m_line; m_run = 0; m_owed = 1'b0;
            m_valid = 1'b1; m_stuffed = 1'b1;
        end else if (v) begin
            m_valid = 1'b1; m_stuffed = 1'b0;
            if (b) begin
                m_run = m_run + 1;
                m_owed = (m_run == RUN_LEN);
            end else begin
                m_line = ~m_line; m_run = 0;
            end
        end else begin
            m_valid = 1'b0; m_stuffed = 1'b0;
        end
    endtask

    // Drive one cycle of inputs away from the edge, then advance the model
    // just after the edge. Returns at posedge+1.
    task automatic step(input logic r, input logic c, input logic v, input logic b);
        @(negedge clk);
        #1;
        nRST = r; clear = c; bit_valid = v; curr_bit = b;
        @(posedge clk);
        #1;
        model_edge(r, c, v, b);
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("cyc_encoded_bit",   encoded_bit,   m_line);
            chk("cyc_encoded_valid", encoded_valid, m_valid);
            chk("cyc_stuff_active",  stuff_active,  m_stuffed);
            chk("cyc_bit_ready",     bit_ready,     ~m_owed);
        end
    end

    logic [7:0] t2_bits;
    logic [7:0] t2_exp;
    logic [6:0] t4_bits;
    logic [6:0] t4_exp;
    logic       hold_bit;
    logic       hold_valid;

    initial begin
        nRST = 1'b1; clear = 1'b0; bit_valid = 1'b0; curr_bit = 1'b0;

        // T1 reset held two clocks
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checking = 1'b1;
        chk("t1_encoded_bit",   encoded_bit,   1'b1);
        chk("t1_encoded_valid", encoded_valid, 1'b0);
        chk("t1_bit_ready",     bit_ready,     1'b1);

        // T2 plain NRZI, index 7 first
        t2_bits = 8'b1001_1010;
        t2_exp  = 8'b1011_1001;
        for (int i = 7; i >= 0; i--) begin
            step(0, 0, 1, t2_bits[i]);
            chk("t2_encoded_bit",   encoded_bit,   t2_exp[i]);
            chk("t2_encoded_valid", encoded_valid, 1'b1);
        end

        // T3 seven 1s: six accepted, a stuffed toggle, then the seventh
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 1);
            chk("t3_run_encoded_bit", encoded_bit, 1'b1);
        end
        chk("t3_ready_low", bit_ready, 1'b0);
        step(0, 0, 1, 1);
        chk("t3_stuff_encoded_bit", encoded_bit,   1'b0);
        chk("t3_stuff_active",      stuff_active,  1'b1);
        chk("t3_stuff_valid",       encoded_valid, 1'b1);
        chk("t3_ready_back",        bit_ready,     1'b1);
        step(0, 0, 1, 1);
        chk("t3_seventh_encoded_bit", encoded_bit,  1'b0);
        chk("t3_seventh_stuff",       stuff_active, 1'b0);

        // T4 run of five broken by a 0: no stuffing
        step(1, 0, 0, 0);
        t4_bits = 7'b11111_0_1;
        t4_exp  = 7'b11111_0_0;
        for (int i = 6; i >= 0; i--) begin
            step(0, 0, 1, t4_bits[i]);
            chk("t4_encoded_bit", encoded_bit,  t4_exp[i]);
            chk("t4_no_stuff",    stuff_active, 1'b0);
            chk("t4_ready",       bit_ready,    1'b1);
        end
        // Counter restarted at the 0: four more 1s make five, sixth stuffs
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
        chk("t4_five_ready", bit_ready, 1'b1);
        step(0, 0, 1, 1);
        chk("t4_six_ready", bit_ready, 1'b0);

        // T5 gap inside a run of 1s
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("t5_gap_encoded_bit",   encoded_bit,   1'b1);
            chk("t5_gap_encoded_valid", encoded_valid, 1'b0);
        end
        step(0, 0, 1, 1);
        chk("t5_sixth_ready", bit_ready, 1'b0);
        step(0, 0, 0, 0);
        chk("t5_stuff_encoded_bit", encoded_bit,  1'b0);
        chk("t5_stuff_active",      stuff_active, 1'b1);

        // T6 clear, then reset, on the cycle a stuff is pending (line low)
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 0, 0);
            step(0, 0, 1, 0);
            for (int i = 0; i < 6; i++) step(0, 0, 1, 1);
            chk("t6_pending", bit_ready, 1'b0);
            if (k == 0) step(0, 1, 1, 1);
            else        step(1, 0, 1, 1);
            chk("t6_encoded_bit",   encoded_bit,   1'b1);
            chk("t6_encoded_valid", encoded_valid, 1'b0);
            chk("t6_stuff_active",  stuff_active,  1'b0);
            chk("t6_bit_ready",     bit_ready,     1'b1);
        end

        // Random traffic; a stalled bit is held by the source until accepted
        hold_valid = 1'b0;
        hold_bit   = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic r, c, v, b;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 59) == 0);
            if (hold_valid) begin
                v = 1'b1;
                b = hold_bit;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                b = ($urandom_range(0, 4) != 0);
            end
            hold_valid = v && m_owed && !r && !c;
            hold_bit   = b;
            step(r, c, v, b);
        end

        step(0, 0, 0, 0);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
